beta_mem_arbiter: RTL

//  Shares the single core-side memory port between instruction fetch (IF) and the load/store unit (LSU).

---
 rtl/beta_pkg.sv | 15 +
 rtl/beta_arb_owner_fifo.sv | 59 +++++
 rtl/beta_mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/beta_pkg.sv
// Shared types for the beta memory arbiter: FSM states and transaction owner tags.
package beta_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_HOLD_IF  = 2'd1,
    ARB_HOLD_LSU = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWNER_IF  = 1'b0,
    ARB_OWNER_LSU = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/beta_arb_owner_fifo.sv
// Circular FIFO of owner tags, one entry per granted-but-unanswered memory transaction.
module beta_arb_owner_fifo
  import beta_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  arb_owner_t push_owner,
  input  logic       pop,
  output arb_owner_t head_owner,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  arb_owner_t            slots [Depth];
  logic       [PtrW-1:0] wr_ptr;
  logic       [PtrW-1:0] rd_ptr;
  logic       [CntW-1:0] count;
  logic                  push_ok;
  logic                  pop_ok;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full       = (count == CntW'(Depth));
  assign empty      = (count == '0);
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign head_owner = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      slots[wr_ptr] <= push_owner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/beta_mem_arbiter.sv
// Shares one OBI-style memory port between instruction fetch and the LSU,
// tracking outstanding transactions so each response returns to its owner in order.
module beta_mem_arbiter
  import beta_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned MaxLsuStreak   = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   arb_if_req_i,
  input  logic [AddrWidth-1:0]   arb_if_addr_i,
  output logic                   arb_if_gnt_o,
  output logic                   arb_if_rvalid_o,
  output logic [DataWidth-1:0]   arb_if_rdata_o,
  output logic                   arb_if_err_o,
  input  logic                   arb_lsu_req_i,
  input  logic                   arb_lsu_we_i,
  input  logic [DataWidth/8-1:0] arb_lsu_be_i,
  input  logic [AddrWidth-1:0]   arb_lsu_addr_i,
  input  logic [DataWidth-1:0]   arb_lsu_wdata_i,
  output logic                   arb_lsu_gnt_o,
  output logic                   arb_lsu_rvalid_o,
  output logic [DataWidth-1:0]   arb_lsu_rdata_o,
  output logic                   arb_lsu_err_o,
  output logic                   arb_mem_req_o,
  output logic                   arb_mem_we_o,
  output logic [DataWidth/8-1:0] arb_mem_be_o,
  output logic [AddrWidth-1:0]   arb_mem_addr_o,
  output logic [DataWidth-1:0]   arb_mem_wdata_o,
  input  logic                   arb_mem_gnt_i,
  input  logic                   arb_mem_rvalid_i,
  input  logic [DataWidth-1:0]   arb_mem_rdata_i,
  input  logic                   arb_mem_err_i,
  output logic                   arb_busy_o
);

  localparam int unsigned StreakW = $clog2(MaxLsuStreak + 1);

  arb_state_t           state_q;
  arb_state_t           state_d;
  arb_owner_t           sel_owner;
  arb_owner_t           head_owner;
  logic [StreakW-1:0]   streak_q;
  logic                 streak_at_max;
  logic                 sel_lsu;
  logic                 mem_req;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  beta_arb_owner_fifo #(
    .Depth (MaxOutstanding)
  ) u_owner_fifo (
    .clk        (clk_i),
    .rst_n      (rstn_i),
    .push       (push),
    .push_owner (sel_owner),
    .pop        (pop),
    .head_owner (head_owner),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign streak_at_max = (streak_q == StreakW'(MaxLsuStreak));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // HOLD states keep the mux locked so an ungranted request stays stable on the bus.
  always_comb begin
    state_d   = state_q;
    sel_owner = ARB_OWNER_IF;
    mem_req   = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (!fifo_full && (arb_if_req_i || arb_lsu_req_i)) begin
          mem_req   = 1'b1;
          sel_owner = (arb_lsu_req_i && !(arb_if_req_i && streak_at_max))
                      ? ARB_OWNER_LSU : ARB_OWNER_IF;
          if (!arb_mem_gnt_i) begin
            state_d = (sel_owner == ARB_OWNER_LSU) ? ARB_HOLD_LSU : ARB_HOLD_IF;
          end
        end
      end
      ARB_HOLD_IF: begin
        mem_req   = 1'b1;
        sel_owner = ARB_OWNER_IF;
        if (arb_mem_gnt_i) state_d = ARB_IDLE;
      end
      ARB_HOLD_LSU: begin
        mem_req   = 1'b1;
        sel_owner = ARB_OWNER_LSU;
        if (arb_mem_gnt_i) state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign sel_lsu = (sel_owner == ARB_OWNER_LSU);
  assign push    = mem_req && arb_mem_gnt_i;
  assign pop     = arb_mem_rvalid_i && !fifo_empty;

  assign arb_mem_req_o   = mem_req;
  assign arb_mem_we_o    = sel_lsu ? arb_lsu_we_i    : 1'b0;
  assign arb_mem_be_o    = sel_lsu ? arb_lsu_be_i    : '1;
  assign arb_mem_addr_o  = sel_lsu ? arb_lsu_addr_i  : arb_if_addr_i;
  assign arb_mem_wdata_o = sel_lsu ? arb_lsu_wdata_i : '0;

  assign arb_if_gnt_o  = push && !sel_lsu;
  assign arb_lsu_gnt_o = push && sel_lsu;

  assign arb_if_rvalid_o  = pop && (head_owner == ARB_OWNER_IF);
  assign arb_lsu_rvalid_o = pop && (head_owner == ARB_OWNER_LSU);
  assign arb_if_rdata_o   = arb_mem_rdata_i;
  assign arb_lsu_rdata_o  = arb_mem_rdata_i;
  assign arb_if_err_o     = arb_if_rvalid_o && arb_mem_err_i;
  assign arb_lsu_err_o    = arb_lsu_rvalid_o && arb_mem_err_i;

  assign arb_busy_o = !fifo_empty || (state_q != ARB_IDLE);

  // Streak counts LSU wins while IF is kept waiting; reaching the limit hands IF the next slot.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      streak_q <= '0;
    end else if (!arb_if_req_i || arb_if_gnt_o) begin
      streak_q <= '0;
    end else if (arb_lsu_gnt_o && !streak_at_max) begin
      streak_q <= streak_q + StreakW'(1);
    end
  end

  a_no_orphan_rvalid : assert property (
    @(posedge clk_i) disable iff (!rstn_i) !(arb_mem_rvalid_i && fifo_empty)
  );

endmodule
